// File: rtl/switch_pkg.sv
// Shared types and widths for the switch port ingress stage.
package switch_pkg;

  localparam int unsigned PORT_W = 4;
  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic [PORT_W-1:0] target;
    logic [DATA_W-1:0] data;
  } ingress_entry_t;

  typedef enum logic [1:0] {IDLE, SEND, GAP} ingress_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; power-of-two depth.
module sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push_c = push && (count != CW'(DEPTH));
  assign do_pop_c  = pop && (count != '0);
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop_c)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/switch_port_ingress.sv
// Host-side ingress for one switch port: filter, buffer, and replay packets
// onto the valid-only switch input with a programmable minimum idle gap.
module switch_port_ingress
  import switch_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned MIN_GAP = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [3:0]              host_target,
  input  logic [7:0]              host_data,
  output logic                    sw_valid,
  output logic [3:0]              sw_source,
  output logic [3:0]              sw_target,
  output logic [7:0]              sw_data,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             drop_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = PORT_W + DATA_W;
  localparam int unsigned GW = 4;

  ingress_state_t  state;
  ingress_entry_t  wr_entry;
  ingress_entry_t  head;
  logic [GW-1:0]   gap_cnt;
  logic            accept_c;
  logic            drop_c;
  logic            push_c;
  logic            load_c;

  assign host_ready = !rst && (fifo_count != CW'(DEPTH));
  assign accept_c   = host_valid && host_ready;
  // Unaddressed packets and packets looping back to our own port never enter the FIFO.
  assign drop_c     = (host_target == '0) || host_target[PORT_ID];
  assign push_c     = accept_c && !drop_c;
  assign wr_entry   = '{target: host_target, data: host_data};
  assign sw_source  = PORT_W'(1'b1) << PORT_ID;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (load_c),
    .din   (wr_entry),
    .dout  (head),
    .count (fifo_count)
  );

  // Pop decision uses registered occupancy, so a same-cycle push is not yet visible.
  always_comb begin
    load_c = 1'b0;
    if (fifo_count != '0) begin
      case (state)
        IDLE:    load_c = 1'b1;
        SEND:    load_c = (MIN_GAP == 0);
        GAP:     load_c = (gap_cnt == '0);
        default: load_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sw_valid  <= 1'b0;
      sw_target <= '0;
      sw_data   <= '0;
      gap_cnt   <= '0;
    end else begin
      sw_valid  <= load_c;
      sw_target <= load_c ? head.target : '0;
      sw_data   <= load_c ? head.data : '0;
      case (state)
        IDLE: begin
          if (load_c) state <= SEND;
        end
        SEND: begin
          if (MIN_GAP != 0) begin
            gap_cnt <= GW'(MIN_GAP - 1);
            state   <= GAP;
          end else if (!load_c) begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          else               state   <= load_c ? SEND : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of filtered packets.
  always_ff @(posedge clk) begin
    if (rst)                                                     drop_count <= '0;
    else if (accept_c && drop_c && (drop_count != 16'hFFFF))     drop_count <= drop_count + 16'd1;
  end

endmodule
